// File: rtl/fifo_read_ctrl_if.sv
// Read-side bundle of the RAM-backed FIFO: the write pointer coming in from the
// write side, the synchronous RAM read port, the consumer stream and the status
// outputs. "master" is the read controller; "slave" is everything around it.
interface fifo_read_ctrl_if #(
   parameter int WIDTH     = 8,
   parameter int DEPTH_LOG = 8
);
   // Pointer from the write-side controller (one extra wrap bit)
   logic [DEPTH_LOG:0]   ram_write_addr;

   // Synchronous RAM read port, one-cycle latency
   logic                 ram_read_req;
   logic [DEPTH_LOG:0]   ram_read_addr;
   logic [WIDTH-1:0]     ram_read_data;

   // First-word-fall-through consumer stream
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic                 out_ready;

   // Status
   logic                 fifo_empty;
   logic [DEPTH_LOG+1:0] fifo_count;

   modport master (
      input  ram_write_addr,
      input  ram_read_data,
      input  out_ready,
      output ram_read_req,
      output ram_read_addr,
      output out_valid,
      output out_data,
      output fifo_empty,
      output fifo_count
   );

   modport slave (
      output ram_write_addr,
      output ram_read_data,
      output out_ready,
      input  ram_read_req,
      input  ram_read_addr,
      input  out_valid,
      input  out_data,
      input  fifo_empty,
      input  fifo_count
   );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the RAM-backed FIFO. Owns the read pointer, issues
// reads to a one-cycle-latency synchronous RAM and hides that latency behind a
// 2-entry output buffer so the consumer sees a first-word-fall-through stream.
// Reads are only issued when the buffer is guaranteed to have room for the
// returning word, so at most two words are ever committed (buffered + in flight).
module fifo_read_ctrl #(
   parameter int WIDTH     = 8,
   parameter int DEPTH_LOG = 8
) (
   input  logic             clk,
   input  logic             rst,
   fifo_read_ctrl_if.master bus
);

   localparam int PW = DEPTH_LOG + 1;   // pointer width including wrap bit

   // Output buffer occupancy, kept as a small FSM
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_t;

   buf_state_t        r_occ;
   buf_state_t        w_occ_nxt;

   logic [PW-1:0]     r_wr_ptr_q;       // write pointer delayed one cycle
   logic [PW-1:0]     r_rd_ptr;
   logic              r_inflight;       // read issued, data arrives this cycle
   logic [WIDTH-1:0]  r_buf0;           // head word
   logic [WIDTH-1:0]  r_buf1;

   logic [1:0]        w_occ_bits;
   logic [PW-1:0]     w_ram_level;
   logic              w_ram_avail;
   logic              w_pop;
   logic [1:0]        w_committed;
   logic              w_read_req;
   logic              w_slot_hi;
   logic [WIDTH-1:0]  w_buf0_nxt;
   logic [WIDTH-1:0]  w_buf1_nxt;

   assign w_occ_bits  = r_occ;

   // Using the delayed write pointer guarantees a word is never read in the
   // same cycle it is written, giving the RAM write a full cycle to land.
   // The full-width compare keeps a full RAM (wrap bits differ) distinct
   // from an empty one.
   assign w_ram_avail = (r_wr_ptr_q != r_rd_ptr);
   assign w_ram_level = r_wr_ptr_q - r_rd_ptr;

   assign w_pop       = (r_occ != BUF_EMPTY) & bus.out_ready;

   // Words still owned by the buffer after this edge, excluding a new read.
   // Cannot underflow: a pop requires at least one buffered word.
   assign w_committed = w_occ_bits + {1'b0, r_inflight} - {1'b0, w_pop};

   // Issue only if the returning word is certain to find a free slot
   assign w_read_req  = w_ram_avail & (w_committed < 2'd2);

   // Returning word goes behind whatever survives the pop
   assign w_slot_hi   = ((w_occ_bits - {1'b0, w_pop}) != 2'd0);

   // Occupancy next state: +1 on capture, -1 on pop
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned and infers a latch.
      w_occ_nxt = r_occ;
      unique case (r_occ)
         BUF_EMPTY: begin
            if (r_inflight) w_occ_nxt = BUF_ONE;
         end
         BUF_ONE: begin
            if (w_pop && !r_inflight)      w_occ_nxt = BUF_EMPTY;
            else if (!w_pop && r_inflight) w_occ_nxt = BUF_TWO;
         end
         BUF_TWO: begin
            // Reads are throttled so no capture can arrive while full
            if (w_pop) w_occ_nxt = BUF_ONE;
         end
         default: w_occ_nxt = BUF_EMPTY;
      endcase
   end

   // Buffer contents next state: shift on pop, then place the RAM word
   always_comb begin
      w_buf0_nxt = r_buf0;
      w_buf1_nxt = r_buf1;
      if (w_pop) begin
         w_buf0_nxt = r_buf1;
      end
      if (r_inflight) begin
         if (w_slot_hi) w_buf1_nxt = bus.ram_read_data;
         else           w_buf0_nxt = bus.ram_read_data;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         r_wr_ptr_q <= '0;
         r_rd_ptr   <= '0;
         r_inflight <= 1'b0;
         r_occ      <= BUF_EMPTY;
         // NOTE: the buffer entries are reset too, because out_data is
         // visible to the consumer and must read zero after reset.
         r_buf0     <= '0;
         r_buf1     <= '0;
      end else begin
         r_wr_ptr_q <= bus.ram_write_addr;
         if (w_read_req) begin
            r_rd_ptr <= r_rd_ptr + {{DEPTH_LOG{1'b0}}, 1'b1};
         end
         r_inflight <= w_read_req;
         r_occ      <= w_occ_nxt;
         r_buf0     <= w_buf0_nxt;
         r_buf1     <= w_buf1_nxt;
      end
   end

   assign bus.ram_read_req  = w_read_req;
   assign bus.ram_read_addr = r_rd_ptr;
   assign bus.out_valid     = (r_occ != BUF_EMPTY);
   assign bus.out_data      = r_buf0;
   assign bus.fifo_empty    = (r_occ == BUF_EMPTY) & ~r_inflight & ~w_ram_avail;

   // Total words held: in the RAM, in flight, and buffered
   assign bus.fifo_count    = {1'b0, w_ram_level}
                            + {{DEPTH_LOG{1'b0}}, w_occ_bits}
                            + {{PW{1'b0}}, r_inflight};

endmodule
